btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front-end stage for the user pushbuttons; feeds the button-driven counter/brightness logic.
- Per button: synchronizes the raw input, debounces it, and emits single-cycle press, release and auto-repeat pulses.
- Downstream logic uses these pulses directly and needs no edge-detect registers of its own.
- N_BTN identical channels, fully independent; all run on the 100 MHz system clock.

Parameters:
- N_BTN, 4, number of button channels
- DB_CYCLES, 2_000_000, consecutive stable cycles needed to accept a new level (20 ms)
- REPEAT_EN, 1, 1 enables auto-repeat pulses; 0 ties btn_repeat to 0
- REPEAT_DELAY, 50_000_000, cycles from press pulse to first repeat pulse (500 ms)
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses (100 ms)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- btn_in  in  N_BTN  raw pushbutton inputs, asynchronous, 1 = pressed
- btn_level  out  N_BTN  debounced level, registered
- btn_press  out  N_BTN  1-cycle pulse when btn_level rises
- btn_release  out  N_BTN  1-cycle pulse when btn_level falls
- btn_repeat  out  N_BTN  1-cycle auto-repeat pulse while held

Behaviour:
- Reset (async assert, sync-domain deassert irrelevant to channels): synchronizer flops, btn_level, btn_press, btn_release, btn_repeat, and all counters = 0; every FSM goes to IDLE.
- Synchronizer: 2-flop chain per bit; s = second stage.
- Debounce counter
  - Counts while s != btn_level.
  - Clears to 0 on any cycle with s == btn_level, so a bounce restarts qualification.
  - When the counter reaches DB_CYCLES-1 with s still != btn_level, btn_level takes s on the next edge and the counter clears.
- Latency: btn_in stable at its new value from clock edge k → btn_level changes at edge k+2+DB_CYCLES.
- Per-channel FSM
  - IDLE (level 0): on accepting 1, go to HELD_WAIT; btn_press=1 for that cycle; repeat counter = 0.
  - HELD_WAIT: repeat counter increments each cycle. When it reaches REPEAT_DELAY-1: btn_repeat=1 (if REPEAT_EN), counter = 0, go to HELD_RPT.
  - HELD_RPT: counter increments each cycle. When it reaches REPEAT_PERIOD-1: btn_repeat=1, counter = 0.
  - Any HELD state: on accepting 0, go to IDLE; btn_release=1; repeat counter = 0.
- Pulses are registered and asserted in the same cycle btn_level changes (press/release) or the terminal count is hit (repeat).
- Release and a due repeat in the same cycle: release wins, btn_repeat=0.
- Mutual exclusion per channel per cycle: at most one of press, release, repeat is asserted.
- REPEAT_EN=0: FSM never leaves HELD_WAIT for HELD_RPT; btn_repeat constant 0; repeat counter may be optimized away.
- Counter widths
  - Debounce counter: $clog2(DB_CYCLES+1).
  - Repeat counter: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - Counters never wrap: terminal compare always precedes overflow.
- Legal parameters: DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD ≥ 1. Illegal values are caught by an elaboration-time check.
- Button held through reset: after deassert it is qualified as a fresh press, so btn_press fires 2+DB_CYCLES cycles later.
- Reset mid-debounce or mid-repeat: all progress is discarded; no pulse is emitted during or on exit from reset.
- Channels share no state: simultaneous events on different buttons are each reported in their own bit.

Decomposition:
- Shared package btn_pkg
  - FSM state typedef: IDLE, HELD_WAIT, HELD_RPT.
  - Width helper function (clog2 of the max of its arguments).
  - Default timing constants for 100 MHz: DB_20MS, RPT_DELAY_500MS, RPT_PERIOD_100MS.
- One sub-module, btn_channel: synchronizer, debounce counter, FSM and repeat counter for one bit.
- The top generate-loops N_BTN instances of btn_channel.

Test Plan:
(All scenarios use DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless noted.)
- Clean press: btn_in[0] 0→1 at edge 10, held → btn_level[0]=1 and btn_press[0]=1 at edge 16 only; no other bits toggle.
- Bounce: btn_in[1] toggles 1,0,1,0 every 2 cycles from edge 10, then stays 1 from edge 18 → single btn_press[1] at edge 24; no release pulse.
- Auto-repeat: btn_in[2] held high, press pulse at edge P → btn_repeat[2] at P+20, P+28, P+36; released so that the fall is accepted at P+44 → btn_release[2] at P+44 and no repeat at P+44.
- REPEAT_EN=0: btn_in[0] held 100 cycles → exactly one btn_press[0], btn_repeat stays 0.
- Reset mid-hold: btn_in[3]=1 held, reset pulsed at cycle P+10 → all outputs 0 asynchronously; btn_press[3] again 6 cycles after reset deassert.
- Simultaneous: btn_in[0] and btn_in[1] rise on the same edge → both btn_press bits high in the same cycle, each exactly once.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types, timing defaults and width helper for the pushbutton conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD_WAIT = 2'd1,
    HELD_RPT  = 2'd2
  } btn_state_e;

  localparam int unsigned N_BTN_DEF        = 4;
  localparam int unsigned DB_20MS          = 2_000_000;
  localparam int unsigned RPT_DELAY_500MS  = 50_000_000;
  localparam int unsigned RPT_PERIOD_100MS = 10_000_000;

  // Bits needed to hold any value 0..max(a,b) without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return 32'($clog2(64'(m) + 64'd1));
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle: raw inputs in, debounced level and event pulses out.
interface btn_conditioner_if
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN = N_BTN_DEF
) ();

  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce qualifier, press/release/repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_20MS,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = RPT_DELAY_500MS,
  parameter int unsigned REPEAT_PERIOD = RPT_PERIOD_100MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned DB_W  = cnt_width(DB_CYCLES, DB_CYCLES);
  localparam int unsigned RPT_W = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [DB_W-1:0]  db_cnt_q;
  logic             accept_c;

  btn_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             press_d, release_d, repeat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // New level is accepted on the edge after DB_CYCLES consecutive differing samples.
  assign accept_c = (sync_q2 != btn_level) && (db_cnt_q == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q  <= '0;
      btn_level <= 1'b0;
    end else if (sync_q2 == btn_level) begin
      db_cnt_q  <= '0;
    end else if (accept_c) begin
      db_cnt_q  <= '0;
      btn_level <= sync_q2;
    end else begin
      db_cnt_q  <= db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rpt_cnt_q   <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rpt_cnt_q   <= rpt_cnt_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_repeat  <= repeat_d;
    end
  end

  // Release takes priority over a repeat falling due in the same cycle.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c && sync_q2) begin
          state_d   = HELD_WAIT;
          press_d   = 1'b1;
          rpt_cnt_d = '0;
        end
      end
      HELD_WAIT, HELD_RPT: begin
        if (accept_c && !sync_q2) begin
          state_d   = IDLE;
          release_d = 1'b1;
          rpt_cnt_d = '0;
        end else if (!REPEAT_EN) begin
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == ((state_q == HELD_WAIT) ? DELAY_LAST : PERIOD_LAST)) begin
          state_d   = HELD_RPT;
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton front end: N_BTN independent synchronize/debounce/event channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = N_BTN_DEF,
  parameter int unsigned DB_CYCLES     = DB_20MS,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = RPT_DELAY_500MS,
  parameter int unsigned REPEAT_PERIOD = RPT_PERIOD_100MS
) (
  input  logic             clk,
  input  logic             reset,
  btn_conditioner_if.slave bus
);

  if (N_BTN == 0 || DB_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_chk
    $error("btn_conditioner: N_BTN, DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 1");
  end

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] repeat_w;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (bus.btn_in[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i]),
      .btn_repeat  (repeat_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_repeat  = repeat_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: directed button waveforms queue expected pulses; monitors pop on each pulse.
module tb_btn_conditioner;

  localparam int unsigned NB = 4;

  typedef struct {
    int             cyc;
    logic [NB-1:0]  press;
    logic [NB-1:0]  rel;
    logic [NB-1:0]  rpt;
    logic [NB-1:0]  lvl;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  btn_conditioner_if #(.N_BTN(NB)) ifa ();
  btn_conditioner_if #(.N_BTN(NB)) ifb ();

  btn_conditioner #(
    .N_BTN(NB), .DB_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  btn_conditioner #(
    .N_BTN(NB), .DB_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compare_rec(input string tag, input exp_t e, input logic [NB-1:0] p,
                             input logic [NB-1:0] r, input logic [NB-1:0] t, input logic [NB-1:0] l);
    check({tag, " cycle"},   cyc,    e.cyc);
    check({tag, " press"},   int'(p), int'(e.press));
    check({tag, " release"}, int'(r), int'(e.rel));
    check({tag, " repeat"},  int'(t), int'(e.rpt));
    check({tag, " level"},   int'(l), int'(e.lvl));
  endtask

  task automatic exp_a(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                       input logic [NB-1:0] t, input logic [NB-1:0] l);
    qa.push_back('{c, p, r, t, l});
  endtask

  task automatic exp_b(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                       input logic [NB-1:0] t, input logic [NB-1:0] l);
    qb.push_back('{c, p, r, t, l});
  endtask

  // Returns #1 after posedge number n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if ((ifa.btn_press | ifa.btn_release | ifa.btn_repeat) != '0) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut_a unexpected pulse: press=%b release=%b repeat=%b, required none (cycle %0d)",
                 ifa.btn_press, ifa.btn_release, ifa.btn_repeat, cyc);
      end else begin
        e = qa.pop_front();
        compare_rec("dut_a", e, ifa.btn_press, ifa.btn_release, ifa.btn_repeat, ifa.btn_level);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if ((ifb.btn_press | ifb.btn_release | ifb.btn_repeat) != '0) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut_b unexpected pulse: press=%b release=%b repeat=%b, required none (cycle %0d)",
                 ifb.btn_press, ifb.btn_release, ifb.btn_repeat, cyc);
      end else begin
        e = qb.pop_front();
        compare_rec("dut_b", e, ifb.btn_press, ifb.btn_release, ifb.btn_repeat, ifb.btn_level);
      end
    end
  end

  initial begin
    ifa.btn_in = '0;
    ifb.btn_in = '0;

    wait_edge(2);
    check("reset a level",   int'(ifa.btn_level),   0);
    check("reset a press",   int'(ifa.btn_press),   0);
    check("reset a release", int'(ifa.btn_release), 0);
    check("reset a repeat",  int'(ifa.btn_repeat),  0);
    check("reset b level",   int'(ifb.btn_level),   0);
    check("reset b press",   int'(ifb.btn_press),   0);
    wait_edge(3);
    reset = 1'b0;

    // Clean press on bit 0; held long enough that release coincides with the first due repeat.
    wait_edge(10);
    ifa.btn_in[0] = 1'b1;
    ifb.btn_in[0] = 1'b1;
    exp_a(16, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    exp_b(16, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_edge(30);
    ifa.btn_in[0] = 1'b0;
    exp_a(36, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

    // Bouncing bit 1: toggles every 2 cycles, settles high at 58.
    exp_a(64, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      wait_edge(50 + 2 * k);
      ifa.btn_in[1] = ((k % 2) == 0);
    end
    wait_edge(66);
    ifa.btn_in[1] = 1'b0;
    exp_a(72, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

    // Auto-repeat on bit 2, release accepted exactly when the fourth repeat is due.
    wait_edge(80);
    ifa.btn_in[2] = 1'b1;
    exp_a(86,  4'b0100, 4'b0000, 4'b0000, 4'b0100);
    exp_a(106, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    exp_a(114, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    exp_a(122, 4'b0000, 4'b0000, 4'b0100, 4'b0100);

    wait_edge(110);
    ifb.btn_in[0] = 1'b0;
    exp_b(116, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

    wait_edge(124);
    ifa.btn_in[2] = 1'b0;
    exp_a(130, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

    // Simultaneous press and release on bits 0 and 1.
    wait_edge(140);
    ifa.btn_in[1:0] = 2'b11;
    exp_a(146, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    wait_edge(150);
    ifa.btn_in[1:0] = 2'b00;
    exp_a(156, 4'b0000, 4'b0011, 4'b0000, 4'b0000);

    // Bit 3 held through a reset pulse: outputs clear at once, fresh press after deassert.
    wait_edge(170);
    ifa.btn_in[3] = 1'b1;
    exp_a(176, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    wait_edge(186);
    check("pre-reset a level", int'(ifa.btn_level), 8);
    reset = 1'b1;
    #1;
    check("async reset a level",   int'(ifa.btn_level),   0);
    check("async reset a press",   int'(ifa.btn_press),   0);
    check("async reset a release", int'(ifa.btn_release), 0);
    check("async reset a repeat",  int'(ifa.btn_repeat),  0);
    wait_edge(188);
    reset = 1'b0;
    exp_a(194, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    wait_edge(200);
    ifa.btn_in[3] = 1'b0;
    exp_a(206, 4'b0000, 4'b1000, 4'b0000, 4'b0000);

    wait_edge(230);
    check("dut_a pending expectations", qa.size(), 0);
    check("dut_b pending expectations", qb.size(), 0);
    check("final a level", int'(ifa.btn_level), 0);
    check("final b level", int'(ifb.btn_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
